systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencer for a ROWS x COLS grid of 8-bit signed multiply-accumulate PEs. It accepts one job per start/done handshake and generates the grid-wide mode, load and drain controls. It also produces per-row skewed feed enables and per-column result-capture strobes. It sits between the job/buffer logic and the PE array, and supports weight-stationary (WS) and output-stationary (OS) jobs.

## Interface
- ROWS, 4, PE rows (2..16)
- COLS, 4, PE columns (2..16)
- KW, 8, width of k_len
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request; sampled only in IDLE
- mode  in  1  1 = WS, 0 = OS; captured with start
- k_len  in  KW  reduction length (activation vectors per job); captured with start
- abort  in  1  synchronous abort, highest priority
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a job completes or aborts
- data_flow  out  1  PE mode; holds the captured mode, 0 after reset
- load  out  1  WS weight load, broadcast to all PEs
- drain  out  1  OS result drain, broadcast to all PEs
- w_row  out  clog2(ROWS)  weight row index presented at the top edge during LOAD
- feed_en  out  ROWS  row r: present the activation on the left edge this cycle
- feed_idx  out  KW  activation index; feed row r uses feed_idx - r
- res_valid  out  COLS  column c bottom output holds a valid result this cycle

## Operation
- States: IDLE, LOAD, FEED, FLUSH, DRAIN, DONE. One down-counter `cnt` of width max(KW, 6)+1.
- IDLE, start=1, k_len>0:
  - Capture mode and k_len; assert data_flow=mode.
  - Next state is LOAD if WS, FEED if OS.
- IDLE, start=1, k_len=0: go directly to DONE. No load, feed or drain is issued.
- LOAD (WS only): ROWS cycles, load=1.
  - w_row counts ROWS-1 down to 0; the first row fed ends in the bottom PE row.
  - Then go to FEED.
- FEED: k_len+ROWS-1 cycles.
  - feed_idx counts 0 upward.
  - feed_en[r]=1 when r <= feed_idx < r+k_len. This is the diagonal skew: row r lags row r-1 by one cycle.
- FLUSH: COLS+ROWS+1 cycles, all feeds off. Covers the multiplier 1-cycle latency plus array propagation.
  - WS: go to DONE.
  - OS: go to DRAIN.
- DRAIN (OS only): ROWS cycles, drain=1.
  - PEs output their accumulator on the first drain cycle, then pass through.
  - The PE accumulator clears when drain falls.
- DONE: one cycle, done=1, then IDLE.
- WS res_valid[c]: high for k_len cycles starting at FEED cycle ROWS+c+1, counting from FEED cycle 0. The strobe may run into FLUSH.
- OS res_valid: all bits high for ROWS cycles starting one cycle after drain rises, covering DRAIN cycles 1..ROWS-1 plus one cycle into DONE. Bottom-row result first.
- abort=1 in any non-IDLE state:
  - Next cycle: DONE, with load, drain and feed_en forced to 0.
  - res_valid=0 from that cycle onward.
  - abort in IDLE or DONE has no effect.
- start while busy: ignored, not queued.
- mode and k_len changes while busy: ignored; the captured copies are used.

## Timing
- Reset values:
  - busy, done, data_flow, load, drain: 0
  - w_row, feed_idx: 0
  - feed_en, res_valid: all 0
  - state: IDLE
- All outputs are registered. No combinational path from inputs to outputs.
- start is seen at edge N; busy=1 and the first LOAD or FEED cycle begin at edge N+1.
- WS job length, start edge to done pulse inclusive: ROWS + (k_len+ROWS-1) + (COLS+ROWS+1) + 1 cycles.
- OS job length: (k_len+ROWS-1) + (COLS+ROWS+1) + ROWS + 1 cycles.
- busy falls in the same cycle done falls. A new start is accepted at the first IDLE edge, so the minimum gap between jobs is 1 cycle.
- Reset asserted mid-job: everything returns to reset values immediately and no done is issued.

## Test plan
- WS, ROWS=COLS=4, k_len=3, start pulse:
  - load high 4 cycles with w_row 3,2,1,0.
  - feed_en[0] high cycles 0–2 of FEED, feed_en[3] high cycles 3–5.
  - res_valid[0] high at FEED cycles 5–7.
  - done at cycle 19 after start.
- OS, 4x4, k_len=5:
  - No load; FEED lasts 8 cycles, FLUSH 9, drain high 4.
  - res_valid high 4 cycles beginning 1 after drain rises.
  - Golden comparison: bottom-row result = exact sum of 5 signed 8-bit products on the PE array.
- k_len=0 start: done one cycle later; load, drain and feed_en never asserted; busy high for exactly 1 cycle.
- abort during FEED cycle 2: next cycle done=1 with feed_en=0 and res_valid=0; the following cycle IDLE. A start in that IDLE cycle begins a new job normally.
- start held high continuously:
  - Jobs run back-to-back with 1 IDLE cycle between done and the next busy.
  - A change of mode mid-job does not alter data_flow until the next capture.
- rst_n pulled low during DRAIN: all outputs 0 asynchronously and no done pulse; after release, IDLE.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Job sequencer for a ROWS x COLS systolic MAC array: WS weight load, skewed
// row feeds, flush, OS drain, and per-column result-capture strobes.
module systolic_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [KW-1:0]             k_len,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      data_flow,
  output logic                      load,
  output logic                      drain,
  output logic [$clog2(ROWS)-1:0]   w_row,
  output logic [ROWS-1:0]           feed_en,
  output logic [KW-1:0]             feed_idx,
  output logic [COLS-1:0]           res_valid
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = ((KW > 6) ? KW : 6) + 1;
  localparam int PW = KW + 6;

  typedef enum logic [2:0] {IDLE, LOAD, FEED, FLUSH, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   ph, ph_nxt;
  logic            mode_q, mode_eff;
  logic [KW-1:0]   k_q, k_eff;
  logic            capture, abrt, os_rv;
  logic [ROWS-1:0] feed_en_nxt;
  logic [COLS-1:0] res_valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ph     <= '0;
      mode_q <= 1'b0;
      k_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ph    <= ph_nxt;
      if (capture) begin
        mode_q <= mode;
        k_q    <= k_len;
      end
    end
  end

  // cnt holds remaining cycles-1 of the current state; ph is the cycle index
  // since the first FEED cycle and keeps running through FLUSH.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ph_nxt    = ph;
    capture   = 1'b0;
    abrt      = abort && (state != IDLE) && (state != DONE);
    case (state)
      IDLE: if (start) begin
        if (k_len == '0) begin
          state_nxt = DONE;
        end else begin
          capture = 1'b1;
          ph_nxt  = '0;
          if (mode) begin
            state_nxt = LOAD;
            cnt_nxt   = CW'(ROWS - 1);
          end else begin
            state_nxt = FEED;
            cnt_nxt   = CW'(k_len) + CW'(ROWS - 2);
          end
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          state_nxt = FEED;
          cnt_nxt   = CW'(k_q) + CW'(ROWS - 2);
          ph_nxt    = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      FEED: begin
        ph_nxt = ph + PW'(1);
        if (cnt == '0) begin
          state_nxt = FLUSH;
          cnt_nxt   = CW'(COLS + ROWS);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      FLUSH: begin
        ph_nxt = ph + PW'(1);
        if (cnt == '0) begin
          if (mode_q) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRAIN;
            cnt_nxt   = CW'(ROWS - 1);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abrt) state_nxt = DONE;
  end

  // Output next-values are decoded from the next state so every output is a flop.
  always_comb begin
    mode_eff      = capture ? mode : mode_q;
    k_eff         = capture ? k_len : k_q;
    feed_en_nxt   = '0;
    res_valid_nxt = '0;
    for (int r = 0; r < ROWS; r++)
      feed_en_nxt[r] = (state_nxt == FEED) && (ph_nxt >= PW'(r)) &&
                       (ph_nxt < PW'(r) + PW'(k_eff));
    if (mode_eff && (state_nxt == FEED || state_nxt == FLUSH))
      for (int c = 0; c < COLS; c++)
        res_valid_nxt[c] = (ph_nxt >= PW'(ROWS + c + 1)) &&
                           (ph_nxt <= PW'(ROWS + c) + PW'(k_eff));
    // OS results stream out one cycle behind drain, ending in the DONE cycle.
    os_rv = !mode_eff &&
            (((state_nxt == DRAIN) && (cnt_nxt != CW'(ROWS - 1))) ||
             ((state == DRAIN) && (state_nxt == DONE) && !abrt));
    if (os_rv) res_valid_nxt = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      load      <= 1'b0;
      drain     <= 1'b0;
      w_row     <= '0;
      feed_idx  <= '0;
      feed_en   <= '0;
      res_valid <= '0;
    end else begin
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      load      <= (state_nxt == LOAD);
      drain     <= (state_nxt == DRAIN);
      w_row     <= (state_nxt == LOAD) ? cnt_nxt[RW-1:0] : '0;
      feed_idx  <= (state_nxt == FEED) ? ph_nxt[KW-1:0] : '0;
      feed_en   <= feed_en_nxt;
      res_valid <= res_valid_nxt;
    end
  end

  assign data_flow = mode_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: jobs are queued at issue, and a monitor
// checks each busy window cycle-by-cycle against a timeline model.
module tb_systolic_ctrl;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic busy, done, data_flow, load, drain;
  logic [$clog2(R)-1:0] w_row;
  logic [R-1:0] feed_en;
  logic [KW-1:0] feed_idx;
  logic [C-1:0] res_valid;

  always #5 clk = ~clk;

  systolic_ctrl #(.ROWS(R), .COLS(C), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .k_len(k_len),
    .abort(abort), .busy(busy), .done(done), .data_flow(data_flow),
    .load(load), .drain(drain), .w_row(w_row), .feed_en(feed_en),
    .feed_idx(feed_idx), .res_valid(res_valid)
  );

  typedef struct { bit mode; int k; int ab; } job_t;

  job_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  bit   mon_active = 1'b0;
  logic exp_df = 1'b0;
  logic signed [7:0] a_mem [256];
  logic signed [7:0] w_mem [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Job timeline: [LOAD R (WS)] FEED k+R-1, FLUSH C+R+1, [DRAIN R (OS)], DONE 1.
  function automatic int norm_len(job_t j);
    if (j.k == 0) return 1;
    return (j.mode ? R : 0) + (j.k + R - 1) + (C + R + 1) + (j.mode ? 0 : R) + 1;
  endfunction

  function automatic bit aborted(job_t j);
    return (j.ab >= 0) && (j.ab < norm_len(j) - 1);
  endfunction

  function automatic int job_len(job_t j);
    return aborted(j) ? j.ab + 2 : norm_len(j);
  endfunction

  task automatic model_at(input job_t j, input int i,
                          output logic e_done, output logic e_load, output logic e_drain,
                          output int e_wr, output int e_fi,
                          output logic [R-1:0] e_fe, output logic [C-1:0] e_rv);
    int lo, f, fl, d, t;
    t = job_len(j);
    e_done = (i == t - 1);
    e_load = 1'b0; e_drain = 1'b0; e_wr = -1; e_fi = -1; e_fe = '0; e_rv = '0;
    lo = j.mode ? R : 0;
    f  = i - lo;
    fl = j.k + R - 1;
    d  = f - fl - (C + R + 1);
    if (i < t - 1) begin
      if (i < lo) begin
        e_load = 1'b1;
        e_wr   = R - 1 - i;
      end else if (f < fl) begin
        e_fi = f;
        for (int r = 0; r < R; r++) e_fe[r] = (f >= r) && (f < r + j.k);
      end else if (d >= 0) begin
        e_drain = 1'b1;
        if (d >= 1) e_rv = '1;
      end
      if (j.mode && f >= 0 && d < 0)
        for (int c = 0; c < C; c++) e_rv[c] = (f >= R + c + 1) && (f <= R + c + j.k);
    end else if (!j.mode && j.k > 0 && !aborted(j)) begin
      e_rv = '1;
    end
  endtask

  initial begin : monitor
    job_t cur;
    int i, t, acc, gold, e_wr, e_fi;
    logic e_done, e_load, e_drain;
    logic [R-1:0] e_fe;
    logic [C-1:0] e_rv;
    logic [7:0] idx;
    i = 0; t = 0; acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        exp_df = 1'b0;
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_data_flow", data_flow, 0);
        chk("rst_load", load, 0);       chk("rst_drain", drain, 0);
        chk("rst_w_row", w_row, 0);     chk("rst_feed_idx", feed_idx, 0);
        chk("rst_feed_en", feed_en, 0); chk("rst_res_valid", res_valid, 0);
      end else begin
        if (!mon_active && busy) begin
          if (exp_q.size() == 0) chk("unexpected_busy", busy, 0);
          else begin
            cur = exp_q.pop_front();
            mon_active = 1'b1; i = 0; t = job_len(cur); acc = 0;
            if (cur.k > 0) exp_df = cur.mode;
          end
        end
        if (mon_active) begin
          model_at(cur, i, e_done, e_load, e_drain, e_wr, e_fi, e_fe, e_rv);
          chk("busy", busy, 1);           chk("done", done, e_done);
          chk("data_flow", data_flow, exp_df);
          chk("load", load, e_load);      chk("drain", drain, e_drain);
          if (e_wr >= 0) chk("w_row", w_row, e_wr);
          if (e_fi >= 0) chk("feed_idx", feed_idx, e_fi);
          chk("feed_en", feed_en, e_fe);  chk("res_valid", res_valid, e_rv);
          if (feed_en[R-1]) begin
            idx = feed_idx - 8'(R - 1);
            acc += int'(a_mem[idx]) * int'(w_mem[idx]);
          end
          if (i == t - 1) begin
            if (!cur.mode && cur.k > 0 && !aborted(cur)) begin
              gold = 0;
              for (int x = 0; x < cur.k; x++) gold += int'(a_mem[x]) * int'(w_mem[x]);
              chk("os_bottom_row_sum", acc, gold);
            end
            mon_active = 1'b0;
          end
          i++;
        end else begin
          chk("idle_busy", busy, 0);   chk("idle_done", done, 0);
          chk("idle_load", load, 0);   chk("idle_drain", drain, 0);
          chk("idle_feed_en", feed_en, 0);
          chk("idle_res_valid", res_valid, 0);
          chk("idle_data_flow", data_flow, exp_df);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      abort = 1'($urandom_range(0, 1));
      tick;
    end
    abort = 1'b0;
  endtask

  // Inputs wiggle while busy (opposite mode, random k_len/start) and must be ignored.
  task automatic run_job(input bit m, input int k, input int ab, input bit hold);
    job_t j;
    int t;
    j.mode = m; j.k = k; j.ab = ab;
    t = job_len(j);
    start = 1'b1; mode = m; k_len = KW'(k); abort = 1'b0;
    exp_q.push_back(j);
    tick;
    for (int i = 0; i < t; i++) begin
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      mode  = ~m;
      k_len = KW'($urandom);
      abort = (i == ab) || ((i == t - 1) && ($urandom_range(0, 1) == 1));
      tick;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  initial begin : stim
    job_t j;
    int k, ab, n;
    for (int x = 0; x < 256; x++) begin
      a_mem[x] = 8'($urandom);
      w_mem[x] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    run_job(1'b1, 3, -1, 1'b0);      // WS 4x4 k=3
    idle_cycles(2);
    run_job(1'b0, 5, -1, 1'b0);      // OS 4x4 k=5
    idle_cycles(1);
    run_job(1'b1, 0, -1, 1'b0);      // k_len = 0
    run_job(1'b0, 0, -1, 1'b0);
    idle_cycles(1);
    run_job(1'b1, 4, R + 2, 1'b0);   // abort in FEED cycle 2
    run_job(1'b0, 3, -1, 1'b0);      // start in the IDLE cycle right after
    for (int x = 0; x < 4; x++) run_job(1'(x % 2), 2 + x, -1, 1'b1);
    idle_cycles(2);

    // reset pulled during DRAIN cycle 1 of an OS job
    j.mode = 1'b0; j.k = 2; j.ab = -1;
    start = 1'b1; mode = 1'b0; k_len = 8'd2;
    exp_q.push_back(j);
    tick;
    start = 1'b0;
    for (int i = 0; i < (2 + R - 1) + (C + R + 1) + 1; i++) tick;
    #1 rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    idle_cycles(3);

    for (int x = 0; x < 40; x++) begin
      j.mode = 1'($urandom_range(0, 1));
      k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      j.k = k; j.ab = -1;
      n = norm_len(j);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_job(j.mode, k, ab, 1'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(0, 3)));
    end

    idle_cycles(3);
    chk("queue_drained", exp_q.size(), 0);
    chk("job_closed", mon_active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
